// File: rtl/mp_ram_pkg.sv
`default_nettype none
//============================================================================
// Module      : mp_ram_pkg
// Description : Shared types, constants and helpers for the multi-port RAM.
// Revision    : 1.0 - initial release
//============================================================================
package mp_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] c_DEADBEEF = 32'hDEAD_BEEF;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mp_ram_rr_arbiter.sv
`default_nettype none
//============================================================================
// Module      : rr_arbiter
// Description : Round-robin selector; first requester after the last grant.
// Revision    : 1.0 - initial release
//============================================================================
module rr_arbiter
    import mp_ram_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_last,
    output logic [NUM_PORTS-1:0] o_grant
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    // Scan from last+1 cyclically; the last grant itself is checked last.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_idx = PTR_W'((int'(i_last) + i) % NUM_PORTS);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mp_ram.sv
`default_nettype none
//============================================================================
// Module      : mp_ram
// Description : Multi-port line RAM, one shared array, round-robin service.
// Revision    : 1.0 - initial release
//============================================================================
module mp_ram
    import mp_ram_pkg::*;
#(
    parameter int          NUM_PORTS      = 4,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 128,
    parameter logic [31:0] MEM_SIZE       = 32'h0010_0000,
    parameter logic [31:0] MEM_OFFSET     = 32'h8000_0000,
    parameter int          ACCESS_LATENCY = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_PORTS-1:0]                    strobe_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_PORTS-1:0]                    rw_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o,
    output logic [NUM_PORTS-1:0]                    done_o,
    output logic [NUM_PORTS-1:0]                    err_o
);

    localparam int c_BYTES      = DATA_WIDTH / 8;
    localparam int c_WORDS      = DATA_WIDTH / 32;
    localparam int c_LINE_SHIFT = clog2(c_BYTES);
    localparam int c_LINES      = int'(MEM_SIZE) / c_BYTES;
    localparam int c_IDX_W      = (c_LINES > 1) ? clog2(c_LINES) : 1;
    localparam int c_PTR_W      = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
    localparam int c_CNT_W      = clog2(ACCESS_LATENCY + 1);

    localparam logic [ADDR_WIDTH:0]   c_LO        = (ADDR_WIDTH+1)'(MEM_OFFSET);
    localparam logic [ADDR_WIDTH:0]   c_HI        = c_LO + (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [DATA_WIDTH-1:0] c_LINE_BAD  = {c_WORDS{c_DEADBEEF}};
    localparam logic [c_CNT_W-1:0]    c_CNT_LAST  = c_CNT_W'(ACCESS_LATENCY - 1);

    logic [DATA_WIDTH-1:0] r_mem [c_LINES];

    state_t                                r_state;
    state_t                                w_next_state;
    logic [c_CNT_W-1:0]                    r_cnt;
    logic [NUM_PORTS-1:0]                  r_pending;
    logic [c_PTR_W-1:0]                    r_last;
    logic [c_PTR_W-1:0]                    r_grant;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  r_addr;
    logic [NUM_PORTS-1:0]                  r_rw;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  r_wdata;
    logic [NUM_PORTS-1:0][c_BYTES-1:0]     r_be;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  r_rdata;
    logic [NUM_PORTS-1:0]                  r_done;
    logic [NUM_PORTS-1:0]                  r_err;

    logic [NUM_PORTS-1:0]  w_accept;
    logic [NUM_PORTS-1:0]  w_arb_grant;
    logic [c_PTR_W-1:0]    w_arb_idx;
    logic                  w_grant_en;
    logic                  w_busy_end;
    logic                  w_commit;
    logic                  w_in_range;
    logic [c_IDX_W-1:0]    w_idx;
    logic [DATA_WIDTH-1:0] w_merged;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} >= c_LO) && ({1'b0, addr} < c_HI);
    endfunction

    function automatic logic [c_IDX_W-1:0] line_index(input logic [ADDR_WIDTH-1:0] addr);
        return c_IDX_W'((addr - ADDR_WIDTH'(MEM_OFFSET)) >> c_LINE_SHIFT);
    endfunction

    // Word 0 of a line sits in the most significant 32 bits.
    function automatic int word_lsb(input logic [ADDR_WIDTH-1:0] addr);
        return DATA_WIDTH - 32 - 32 * (int'(addr[ADDR_WIDTH-1:2]) & (c_WORDS - 1));
    endfunction

    function automatic logic [31:0] readWord(input logic [ADDR_WIDTH-1:0] addr);
        if (!addr_in_range(addr)) begin
            return c_DEADBEEF;
        end
        return r_mem[line_index(addr)][word_lsb(addr) +: 32];
    endfunction

    task automatic writeWord(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data);
        if (addr_in_range(addr)) begin
            r_mem[line_index(addr)][word_lsb(addr) +: 32] <= data;
        end
    endtask

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (c_PTR_W)
    ) u_arb (
        .i_req   (r_pending),
        .i_last  (r_last),
        .o_grant (w_arb_grant)
    );

    always_comb begin
        w_arb_idx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_arb_grant[p]) begin
                w_arb_idx = c_PTR_W'(p);
            end
        end
    end

    assign w_accept   = strobe_i & (~r_pending | r_done);
    assign w_in_range = addr_in_range(r_addr[r_grant]);
    assign w_idx      = line_index(r_addr[r_grant]);

    always_comb begin
        w_merged = r_mem[w_idx];
        for (int b = 0; b < c_BYTES; b++) begin
            if (r_be[r_grant][b]) begin
                w_merged[8*b +: 8] = r_wdata[r_grant][8*b +: 8];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (|r_pending) w_next_state = BUSY;
            BUSY:    if (r_cnt == c_CNT_LAST) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_grant_en = 1'b0;
        w_busy_end = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            IDLE:    w_grant_en = |r_pending;
            BUSY:    w_busy_end = (r_cnt == c_CNT_LAST);
            DONE:    w_commit   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_pending <= '0;
            r_last    <= c_PTR_W'(NUM_PORTS - 1);
            r_grant   <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_rw      <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            if (r_state == BUSY) begin
                r_cnt <= w_busy_end ? '0 : r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_grant_en) begin
                r_grant <= w_arb_idx;
                r_last  <= w_arb_idx;
            end
            // Result is staged at the end of BUSY so it is visible in DONE.
            if (w_busy_end) begin
                r_done[r_grant]  <= 1'b1;
                r_err[r_grant]   <= !w_in_range;
                r_rdata[r_grant] <= w_in_range ? r_mem[w_idx] : c_LINE_BAD;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_accept[p]) begin
                    r_pending[p] <= 1'b1;
                    r_addr[p]    <= addr_i[p];
                    r_rw[p]      <= rw_i[p];
                    r_wdata[p]   <= wdata_i[p];
                    r_be[p]      <= be_i[p];
                end else if (w_commit && (r_grant == c_PTR_W'(p))) begin
                    r_pending[p] <= 1'b0;
                end
            end
        end
    end

    // Array is never reset; a reset in DONE suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_rw[r_grant] && w_in_range) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign rdata_o = r_rdata;
    assign done_o  = r_done;
    assign err_o   = r_err;

endmodule
`default_nettype wire
